// File: rtl/uart_baud_gen.sv
// uart_baud_gen -- fractional-N UART baud tick generator.
//
// Produces a one-cycle RX oversample tick (rx_clk_en) every
// div_int + div_frac/2^FRAC_W clk cycles on average. It also produces a
// one-cycle TX bit tick (tx_clk_en) on every OSR-th RX tick.
//
// Build option: define UART_BAUD_FRAC_EN to compile in the fractional
// accumulator. Without it, div_frac is ignored and every period is exactly
// div_int cycles.
//
// Ports:
//   clk        system clock
//   rst_n      asynchronous active-low reset
//   en         generator enable; counters held at zero while low
//   div_int    integer clocks per RX tick (captured on div_load)
//   div_frac   fractional clocks per RX tick, units of 1/2^FRAC_W
//   div_load   pulse: capture divisor, restart all timing
//   tx_restart pulse: realign TX phase (clears the OSR counter only)
//   rx_clk_en  registered RX oversample tick
//   tx_clk_en  registered TX bit tick, coincident with an RX tick
//   cfg_err    active div_int < 2; no ticks are generated
module uart_baud_gen #(
  parameter int unsigned CLK_FREQ  = 50000000,
  parameter int unsigned BAUD_RATE = 9600,
  parameter int unsigned OSR       = 16,
  parameter int unsigned DIV_W     = 16,
  parameter int unsigned FRAC_W    = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              en,
  input  logic [DIV_W-1:0]  div_int,
  input  logic [FRAC_W-1:0] div_frac,
  input  logic              div_load,
  input  logic              tx_restart,
  output logic              rx_clk_en,
  output logic              tx_clk_en,
  output logic              cfg_err
);

  localparam int unsigned OSR_W = $clog2(OSR);
  localparam logic [OSR_W-1:0] OSR_LAST = OSR_W'(OSR - 1);

  localparam longint unsigned DEN      = 64'(BAUD_RATE) * 64'(OSR);
  localparam longint unsigned DIV_RST  = 64'(CLK_FREQ) / DEN;
  localparam longint unsigned FRAC_RST =
    ((64'(CLK_FREQ) << FRAC_W) / DEN) % (64'd1 << FRAC_W);

  logic [DIV_W-1:0] div_int_q;
  logic [DIV_W:0]   cnt_q;    // edges since period start; 0 = not started
  logic [DIV_W:0]   period;
  logic [OSR_W-1:0] osr_q;
  logic             run;
  logic             fire;

  assign cfg_err = (div_int_q < DIV_W'(2));
  assign run     = en && !cfg_err;
  // A tick is produced at the edge where cnt_q reaches the period length;
  // cnt_q restarts at 1 because that same edge is the first of the next period.
  assign fire    = run && !div_load && (cnt_q == period);

`ifdef UART_BAUD_FRAC_EN
  logic [FRAC_W-1:0] div_frac_q;
  logic [FRAC_W-1:0] acc_q;
  logic              long_q;  // carry from the last tick: next period is +1
  logic [FRAC_W:0]   acc_sum;

  assign acc_sum = {1'b0, acc_q} + {1'b0, div_frac_q};
  assign period  = {1'b0, div_int_q} + (DIV_W+1)'(long_q);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      div_frac_q <= FRAC_W'(FRAC_RST);
    end else if (div_load) begin
      div_frac_q <= div_frac;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc_q  <= '0;
      long_q <= 1'b0;
    end else if (div_load || !run) begin
      acc_q  <= '0;
      long_q <= 1'b0;
    end else if (fire) begin
      acc_q  <= acc_sum[FRAC_W-1:0];
      long_q <= acc_sum[FRAC_W];
    end
  end
`else
  logic unused_frac;

  assign unused_frac = ^{div_frac, FRAC_RST};
  assign period      = {1'b0, div_int_q};
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      div_int_q <= DIV_W'(DIV_RST);
    end else if (div_load) begin
      div_int_q <= div_int;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q     <= '0;
      osr_q     <= '0;
      rx_clk_en <= 1'b0;
      tx_clk_en <= 1'b0;
    end else if (div_load || !run) begin
      cnt_q     <= '0;
      osr_q     <= '0;
      rx_clk_en <= 1'b0;
      tx_clk_en <= 1'b0;
    end else begin
      rx_clk_en <= fire;
      cnt_q     <= fire ? (DIV_W+1)'(1) : cnt_q + (DIV_W+1)'(1);
      // A restart landing on a tick edge swallows that tick for TX purposes.
      if (tx_restart) begin
        osr_q     <= '0;
        tx_clk_en <= 1'b0;
      end else if (fire) begin
        if (osr_q == OSR_LAST) begin
          osr_q     <= '0;
          tx_clk_en <= 1'b1;
        end else begin
          osr_q     <= osr_q + OSR_W'(1);
          tx_clk_en <= 1'b0;
        end
      end else begin
        tx_clk_en <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_uart_baud_gen.sv
// tb_uart_baud_gen -- directed self-checking bench for uart_baud_gen
// (default parameters: 325 + 8/16 clocks per RX tick at reset, OSR 16).
module tb_uart_baud_gen;

`ifdef UART_BAUD_FRAC_EN
  localparam int EXP_TOT = 68;
  localparam int EXP_N5  = 4;
`else
  localparam int EXP_TOT = 64;
  localparam int EXP_N5  = 0;
`endif

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        en = 1'b0;
  logic [15:0] div_int = '0;
  logic [3:0]  div_frac = '0;
  logic        div_load = 1'b0;
  logic        tx_restart = 1'b0;
  logic        rx_clk_en;
  logic        tx_clk_en;
  logic        cfg_err;

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  uart_baud_gen #(
    .CLK_FREQ (50000000),
    .BAUD_RATE(9600),
    .OSR      (16),
    .DIV_W    (16),
    .FRAC_W   (4)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .en        (en),
    .div_int   (div_int),
    .div_frac  (div_frac),
    .div_load  (div_load),
    .tx_restart(tx_restart),
    .rx_clk_en (rx_clk_en),
    .tx_clk_en (tx_clk_en),
    .cfg_err   (cfg_err)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  initial begin
    #2000000;
    $display("FAIL watchdog got timeout expected finish");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input longint got, input longint exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Waits for the next rx tick; returns its cycle stamp and the tx level.
  task automatic wait_rx(input int limit, output int t, output logic txs);
    int n;
    n = 0;
    t = -1;
    txs = 1'b0;
    while (n < limit && t < 0) begin
      step();
      n++;
      if (rx_clk_en) begin
        t = cyc;
        txs = tx_clk_en;
      end
    end
    if (t < 0) check("rx_timeout", 0, 1);
  endtask

  // Counts rx ticks up to and including the next tx tick.
  task automatic ticks_to_tx(input int limit, output int k, output int t);
    logic txs;
    k = 0;
    txs = 1'b0;
    t = 0;
    while (!txs && k < 20) begin
      wait_rx(limit, t, txs);
      k++;
    end
  endtask

  task automatic load(input int di, input int df, input logic rs);
    div_int    = 16'(di);
    div_frac   = 4'(df);
    div_load   = 1'b1;
    tx_restart = rs;
    step();
    div_load   = 1'b0;
    tx_restart = 1'b0;
  endtask

  int   t, t0, c0, k, p, n4, n5, tot, quiet;
  logic txs;

  initial begin
    // Reset defaults
    step();
    step();
    check("rst_rx", rx_clk_en, 0);
    check("rst_tx", tx_clk_en, 0);
    check("rst_cfg_err", cfg_err, 0);
    rst_n = 1'b1;
    step();
    en = 1'b1;
    c0 = cyc;
    wait_rx(400, t, txs);
    check("first_tick_325", t - c0 - 1, 325);
    check("first_tick_no_tx", txs, 0);
    k = 1;
    while (!txs && k < 20) begin
      wait_rx(400, t, txs);
      k++;
    end
    check("tx_on_16th", k, 16);

    // Fractional divisor 4 + 4/16
    load(4, 4, 1'b0);
    check("load_rx_supp", rx_clk_en, 0);
    check("load_tx_supp", tx_clk_en, 0);
    c0 = cyc;
    wait_rx(10, t, txs);
    check("load_first_4", t - c0 - 1, 4);
    t0 = t;
    tot = 0;
    n4 = 0;
    n5 = 0;
    for (int i = 0; i < 16; i++) begin
      wait_rx(10, t, txs);
      p = t - t0;
      tot += p;
      if (p == 5) n5++;
      else if (p == 4) n4++;
      t0 = t;
    end
    check("frac_total", tot, EXP_TOT);
    check("frac_n5", n5, EXP_N5);
    check("frac_n4", n4, 16 - EXP_N5);

    // tx_restart 5 rx ticks after a tx tick
    ticks_to_tx(10, k, t);
    for (int i = 0; i < 5; i++) wait_rx(10, t, txs);
    t0 = t;
    tx_restart = 1'b1;
    step();
    tx_restart = 1'b0;
    ticks_to_tx(10, k, t);
    check("restart_tx_16th", k, 16);
    check("restart_rx_span", t - t0, EXP_TOT);

    // Illegal divisor, then a legal one
    load(1, 0, 1'b0);
    check("cfg_err_set", cfg_err, 1);
    quiet = 0;
    for (int i = 0; i < 100; i++) begin
      step();
      quiet += int'(rx_clk_en) + int'(tx_clk_en);
    end
    check("cfg_err_no_ticks", quiet, 0);
    load(3, 0, 1'b0);
    check("cfg_err_clear", cfg_err, 0);
    c0 = cyc;
    wait_rx(10, t, txs);
    check("div3_first", t - c0 - 1, 3);
    for (int i = 0; i < 4; i++) begin
      t0 = t;
      wait_rx(10, t, txs);
      check("div3_spacing", t - t0, 3);
    end

    // tx_restart landing on what would be the 16th tick
    ticks_to_tx(10, k, t);
    for (int i = 0; i < 15; i++) wait_rx(10, t, txs);
    step();
    step();
    tx_restart = 1'b1;
    step();
    tx_restart = 1'b0;
    check("coinc_rx", rx_clk_en, 1);
    check("coinc_tx", tx_clk_en, 0);
    ticks_to_tx(10, k, t);
    check("coinc_tx_16th", k, 16);

    // en dropped mid-period
    load(10, 0, 1'b0);
    wait_rx(20, t, txs);
    for (int i = 0; i < 4; i++) step();
    en = 1'b0;
    quiet = 0;
    for (int i = 0; i < 30; i++) begin
      step();
      quiet += int'(rx_clk_en) + int'(tx_clk_en);
    end
    check("en_low_no_ticks", quiet, 0);
    en = 1'b1;
    c0 = cyc;
    wait_rx(20, t, txs);
    check("reenable_first_10", t - c0 - 1, 10);

    // div_load and tx_restart together: load wins
    step();
    load(6, 0, 1'b1);
    check("both_rx_supp", rx_clk_en, 0);
    check("both_tx_supp", tx_clk_en, 0);
    c0 = cyc;
    wait_rx(20, t, txs);
    check("both_first_6", t - c0 - 1, 6);
    k = 1;
    while (!txs && k < 20) begin
      wait_rx(20, t, txs);
      k++;
    end
    check("both_tx_16th", k, 16);

    // Reset asserted while both ticks are high
    ticks_to_tx(20, k, t);
    rst_n = 1'b0;
    #1;
    check("async_rst_rx", rx_clk_en, 0);
    check("async_rst_tx", tx_clk_en, 0);
    step();
    rst_n = 1'b1;
    c0 = cyc;
    check("rst_cfg_err_again", cfg_err, 0);
    wait_rx(400, t, txs);
    check("rst_first_325", t - c0 - 1, 325);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
